// File: rtl/ir_cam_pkg.sv
// Shared types and constants for the IR camera bring-up sequencer.
package ir_cam_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    GAP,
    POLL_WAIT,
    POLL_ISSUE,
    POLL_DONE,
    FAULT
  } state_t;

  localparam int unsigned NUM_CMDS = 6;

  // Init commands as {val, reg}; reg travels first on the bus (byte 0).
  localparam logic [15:0] CMD_ROM_0 = 16'h0130;
  localparam logic [15:0] CMD_ROM_1 = 16'h0830;
  localparam logic [15:0] CMD_ROM_2 = 16'h9006;
  localparam logic [15:0] CMD_ROM_3 = 16'hC008;
  localparam logic [15:0] CMD_ROM_4 = 16'h401A;
  localparam logic [15:0] CMD_ROM_5 = 16'h3333;

  localparam logic [7:0] POLL_REG     = 8'h36;
  localparam logic [2:0] INIT_PACKETS = 3'd2;
  localparam logic [2:0] POLL_PACKETS = 3'd1;

  localparam logic [23:0] POLL_PAYLOAD = {16'h0000, POLL_REG};

  // Widen a two-byte init command to the flat three-byte payload bus.
  function automatic logic [23:0] init_payload(input logic [15:0] cmd);
    return {8'h00, cmd};
  endfunction

endpackage

// File: rtl/ir_cam_cmd_rom.sv
// Combinational command ROM for the six-entry camera init sequence.
module ir_cam_cmd_rom
  import ir_cam_pkg::*;
(
  input  logic [2:0]  idx,
  output logic [23:0] payload
);

  // Index-to-payload lookup; out-of-range indices read as zero.
  always_comb begin
    payload = '0;
    case (idx)
      3'd0:    payload = init_payload(CMD_ROM_0);
      3'd1:    payload = init_payload(CMD_ROM_1);
      3'd2:    payload = init_payload(CMD_ROM_2);
      3'd3:    payload = init_payload(CMD_ROM_3);
      3'd4:    payload = init_payload(CMD_ROM_4);
      3'd5:    payload = init_payload(CMD_ROM_5);
      default: payload = '0;
    endcase
  end

endmodule

// File: rtl/ir_cam_sequencer.sv
// Drives the single i2c_init engine through camera init, then periodic polling.
module ir_cam_sequencer
  import ir_cam_pkg::*;
#(
  parameter int unsigned CMD_GAP     = 120000,
  parameter int unsigned POLL_PERIOD = 120000,
  parameter int unsigned TIMEOUT     = 12000,
  parameter int unsigned MAX_RETRIES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        reinit,
  output logic        i2c_start,
  output logic [2:0]  i2c_packets,
  output logic [23:0] i2c_data,
  input  logic        i2c_done,
  output logic        init_done,
  output logic        poll_strobe,
  output logic        error
);

  // The shared down-counter is loaded with N-1 so a state lasts exactly N cycles.
  localparam logic [23:0] GAP_LOAD    = 24'(CMD_GAP - 1);
  localparam logic [23:0] POLL_LOAD   = 24'(POLL_PERIOD - 1);
  localparam logic [23:0] TO_LOAD     = 24'(TIMEOUT - 1);
  localparam logic [7:0]  RETRY_LIMIT = 8'(MAX_RETRIES);
  localparam logic [2:0]  LAST_CMD    = 3'(NUM_CMDS - 1);

  state_t      state_q, state_n;
  logic [23:0] cnt_q, cnt_n;
  logic [2:0]  cmd_idx_q, cmd_idx_n;
  logic [7:0]  retries_q, retries_n;
  logic        pend_q, pend_n;

  logic        start_n;
  logic [2:0]  packets_n;
  logic [23:0] data_n;
  logic        init_done_n;
  logic        strobe_n;
  logic        error_n;

  logic [23:0] rom_payload;
  logic        cnt_zero;
  logic        restart;

  ir_cam_cmd_rom u_rom (
    .idx     (cmd_idx_q),
    .payload (rom_payload)
  );

  assign cnt_zero = (cnt_q == '0);

  // A reinit pulse in the same cycle counts as pending; it is only honoured
  // where no transfer is outstanding, and it beats a gap/poll expiry.
  assign restart = (reinit | pend_q) &&
                   (state_q inside {IDLE, GAP, POLL_WAIT, FAULT});

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    cmd_idx_n   = cmd_idx_q;
    retries_n   = retries_q;
    pend_n      = pend_q | reinit;
    start_n     = 1'b0;
    strobe_n    = 1'b0;
    packets_n   = i2c_packets;
    data_n      = i2c_data;
    init_done_n = init_done;
    error_n     = error;

    if (restart) begin
      state_n     = GAP;
      cnt_n       = GAP_LOAD;
      cmd_idx_n   = '0;
      retries_n   = '0;
      init_done_n = 1'b0;
      error_n     = 1'b0;
      pend_n      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            state_n   = GAP;
            cnt_n     = GAP_LOAD;
            cmd_idx_n = '0;
            retries_n = '0;
          end
        end

        GAP: begin
          if (cnt_zero) begin
            state_n   = ISSUE;
            start_n   = 1'b1;
            packets_n = INIT_PACKETS;
            data_n    = rom_payload;
          end else begin
            cnt_n = cnt_q - 24'd1;
          end
        end

        ISSUE: begin
          state_n = WAIT_DONE;
          cnt_n   = TO_LOAD;
        end

        WAIT_DONE: begin
          if (i2c_done) begin
            if (cmd_idx_q == LAST_CMD) begin
              init_done_n = 1'b1;
              state_n     = POLL_WAIT;
              cnt_n       = POLL_LOAD;
            end else begin
              cmd_idx_n = cmd_idx_q + 3'd1;
              retries_n = '0;
              state_n   = GAP;
              cnt_n     = GAP_LOAD;
            end
          end else if (cnt_zero) begin
            if (retries_q < RETRY_LIMIT) begin
              retries_n = retries_q + 8'd1;
              state_n   = GAP;
              cnt_n     = GAP_LOAD;
            end else begin
              error_n = 1'b1;
              state_n = FAULT;
            end
          end else begin
            cnt_n = cnt_q - 24'd1;
          end
        end

        POLL_WAIT: begin
          if (cnt_zero) begin
            state_n   = POLL_ISSUE;
            start_n   = 1'b1;
            packets_n = POLL_PACKETS;
            data_n    = POLL_PAYLOAD;
          end else begin
            cnt_n = cnt_q - 24'd1;
          end
        end

        POLL_ISSUE: begin
          state_n = POLL_DONE;
          cnt_n   = TO_LOAD;
        end

        POLL_DONE: begin
          if (i2c_done) begin
            strobe_n = 1'b1;
            state_n  = POLL_WAIT;
            cnt_n    = POLL_LOAD;
          end else if (cnt_zero) begin
            init_done_n = 1'b0;
            cmd_idx_n   = '0;
            retries_n   = '0;
            state_n     = GAP;
            cnt_n       = GAP_LOAD;
          end else begin
            cnt_n = cnt_q - 24'd1;
          end
        end

        FAULT: begin
          state_n = FAULT;
        end

        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_idx_q   <= '0;
      retries_q   <= '0;
      pend_q      <= 1'b0;
      i2c_start   <= 1'b0;
      i2c_packets <= '0;
      i2c_data    <= '0;
      init_done   <= 1'b0;
      poll_strobe <= 1'b0;
      error       <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      cmd_idx_q   <= cmd_idx_n;
      retries_q   <= retries_n;
      pend_q      <= pend_n;
      i2c_start   <= start_n;
      i2c_packets <= packets_n;
      i2c_data    <= data_n;
      init_done   <= init_done_n;
      poll_strobe <= strobe_n;
      error       <= error_n;
    end
  end

endmodule
